// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: routes each UART command to an execution unit and replies with one status byte
module cmd_dispatcher #(
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT = 1000000,
  parameter logic [7:0] ACK_CODE = 8'hA5,
  parameter logic [7:0] NAK_CODE = 8'hEE,
  parameter logic [7:0] TMO_CODE = 8'hE0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_rdy,
  input  logic [15:0]          cmd,
  output logic                 clr_cmd_rdy,
  output logic [NUM_UNITS-1:0] exec_vld,
  output logic [11:0]          exec_data,
  input  logic [NUM_UNITS-1:0] exec_done,
  input  logic                 exec_err,
  output logic                 trmt,
  output logic [7:0]           resp,
  input  logic                 tx_done,
  output logic                 busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_DONE, SEND, WAIT_TX} state_t;
  state_t state, nxt;
  logic [3:0] op;
  logic [CW-1:0] ctr;
  logic blank, take, legal, done, tmo;
  logic [NUM_UNITS-1:0] sel, new_sel;
  logic [7:0] resp_nxt;
  assign take = state == IDLE && cmd_rdy;
  assign legal = 32'(op) < NUM_UNITS;
  assign sel = legal ? NUM_UNITS'(1) << op : '0;
  assign new_sel = 32'(cmd[15:12]) < NUM_UNITS ? NUM_UNITS'(1) << cmd[15:12] : '0;
  assign done = |(exec_done & sel);
  assign tmo = ctr >= CW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    resp_nxt = resp;
    case (state)
      IDLE: nxt = cmd_rdy ? DISPATCH : IDLE;
      DISPATCH: begin
        nxt = legal ? WAIT_DONE : SEND;
        resp_nxt = legal ? resp : NAK_CODE;
      end
      WAIT_DONE: begin
        nxt = (done || tmo) ? SEND : WAIT_DONE;
        resp_nxt = done ? (exec_err ? NAK_CODE : ACK_CODE) : tmo ? TMO_CODE : resp;
      end
      SEND: nxt = WAIT_TX;
      // blank masks the tx_done level left over from the previous transfer
      WAIT_TX: nxt = (tx_done && !blank) ? IDLE : WAIT_TX;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      clr_cmd_rdy <= 1'b0;
      exec_vld <= '0;
      exec_data <= '0;
      op <= '0;
      trmt <= 1'b0;
      resp <= '0;
      busy <= 1'b0;
      ctr <= '0;
      blank <= 1'b0;
    end else begin
      state <= nxt;
      clr_cmd_rdy <= take;
      exec_vld <= take ? new_sel : '0;
      if (take) begin
        op <= cmd[15:12];
        exec_data <= cmd[11:0];
      end
      trmt <= nxt == SEND;
      resp <= resp_nxt;
      busy <= nxt != IDLE;
      ctr <= state == WAIT_DONE ? (ctr == CW'(TIMEOUT) ? ctr : ctr + 1'b1) : '0;
      blank <= nxt == WAIT_TX && state != WAIT_TX;
    end
  end
endmodule
